// File: rtl/sp_pkg.sv
// Shared types and constants for the stack pointer unit.
// Fault codes, FSM states and default stack bounds.
package sp_pkg;

  localparam int          SP_WIDTH  = 8;
  localparam logic [7:0]  SP_TOP    = 8'hFF;
  localparam logic [7:0]  SP_BOTTOM = 8'hC0;

  typedef enum logic [1:0] {
    FC_NONE = 2'b00,
    FC_OVF  = 2'b01,
    FC_UNF  = 2'b10,
    FC_LOAD = 2'b11
  } fault_code_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

endpackage

// File: rtl/sp_step.sv
// Decrement/increment pair for the stack pointer.
// Ports: i_in -> o_dec = i_in-1, o_inc = i_in+1 (modulo 2^WIDTH).
module sp_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_dec,
  output logic [WIDTH-1:0] o_inc
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  assign o_dec = i_in - ONE;
  assign o_inc = i_in + ONE;

endmodule

// File: rtl/stack_pointer_unit.sv
// Down-growing stack pointer with registered address issue and fault FSM.
// Ports: clock/reset, push/pop/load requests, sp, mem_addr, addr_valid,
//   is_push, empty/full/depth (from sp), fault and fault_code.
module stack_pointer_unit
  import sp_pkg::*;
#(
  parameter int               WIDTH  = SP_WIDTH,
  parameter logic [WIDTH-1:0] TOP    = SP_TOP,
  parameter logic [WIDTH-1:0] BOTTOM = SP_BOTTOM
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_clear_fault,
  output logic [WIDTH-1:0] o_sp,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic             o_addr_valid,
  output logic             o_is_push,
  output logic             o_empty,
  output logic             o_full,
  output logic [WIDTH-1:0] o_depth,
  output logic             o_fault,
  output logic [1:0]       o_fault_code
);

  logic [WIDTH-1:0] r_sp;
  logic [WIDTH-1:0] r_mem_addr;
  logic             r_addr_valid;
  logic             r_is_push;
  logic             r_fault;
  fault_code_t      r_fault_code;
  state_t           r_state;

  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_inc;
  logic             w_in_range;
  logic             w_at_top;
  logic             w_at_bot;

  sp_step #(.WIDTH(WIDTH)) u_step (
    .i_in  (r_sp),
    .o_dec (w_dec),
    .o_inc (w_inc)
  );

  // One extra bit keeps the bound compares meaningful when TOP is all-ones.
  assign w_in_range = ({1'b0, i_load_val} >= {1'b0, BOTTOM}) &&
                      ({1'b0, i_load_val} <= {1'b0, TOP});
  assign w_at_top   = (r_sp == TOP);
  assign w_at_bot   = (r_sp == BOTTOM);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sp         <= TOP;
      r_mem_addr   <= '0;
      r_addr_valid <= 1'b0;
      r_is_push    <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= FC_NONE;
      r_state      <= RUN;
    end else begin
      r_addr_valid <= 1'b0;
      unique case (r_state)
        RUN: begin
          if (i_load) begin
            if (w_in_range) begin
              r_sp <= i_load_val;
            end else begin
              r_fault_code <= FC_LOAD;
              r_fault      <= 1'b1;
              r_state      <= FAULT;
            end
          end else if (i_push && i_pop) begin
            r_sp <= r_sp;
          end else if (i_push) begin
            if (!w_at_bot) begin
              r_sp         <= w_dec;
              r_mem_addr   <= w_dec;
              r_is_push    <= 1'b1;
              r_addr_valid <= 1'b1;
            end else begin
              r_fault_code <= FC_OVF;
              r_fault      <= 1'b1;
              r_state      <= FAULT;
            end
          end else if (i_pop) begin
            if (!w_at_top) begin
              r_sp         <= w_inc;
              r_mem_addr   <= r_sp;
              r_is_push    <= 1'b0;
              r_addr_valid <= 1'b1;
            end else begin
              r_fault_code <= FC_UNF;
              r_fault      <= 1'b1;
              r_state      <= FAULT;
            end
          end
        end
        FAULT: begin
          // First fault sticks; requests are dropped until cleared.
          if (i_clear_fault) begin
            r_fault_code <= FC_NONE;
            r_fault      <= 1'b0;
            r_state      <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign o_sp         = r_sp;
  assign o_mem_addr   = r_mem_addr;
  assign o_addr_valid = r_addr_valid;
  assign o_is_push    = r_is_push;
  assign o_empty      = w_at_top;
  assign o_full       = w_at_bot;
  assign o_depth      = TOP - r_sp;
  assign o_fault      = r_fault;
  assign o_fault_code = r_fault_code;

endmodule
